// File: rtl/common_cells_pkg.sv
// Shared type definitions for the DMA datapath blocks.
//
// Contents:
//   dma_xfer_state_t : dma_xfer_ctrl FSM state encoding {IDLE, RD, WR, DONE}
package common_cells_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } dma_xfer_state_t;

endpackage

// File: rtl/dma_xfer_ctrl.sv
// dma_xfer_ctrl: memory-to-memory copy controller. Takes one descriptor (src, dst, len),
// then reads a word through the AXI-Lite user read port into a holding register and
// writes it back out through the user write port, one word at a time.
//
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   aenable               global enable; low freezes all state (and therefore outputs)
//   i_start, i_src_addr,
//   i_dst_addr, i_len     descriptor, sampled in IDLE only
//   i_abort               stop at the next word boundary (ignored in IDLE)
//   o_busy, o_done,
//   o_aborted             status: busy outside IDLE, one-cycle done, sticky abort flag
//   o_rd_ready/o_rd_addr, i_rd_valid/i_rd_data               read request / response
//   o_wr_valid/o_wr_addr/o_wr_data/o_wr_strb, i_wr_ready      write request / accept
//
// Build option:
//   DMA_XFER_PERF_EN      adds o_cycle_cnt[31:0], a saturating count of busy cycles
module dma_xfer_ctrl
    import common_cells_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  aenable,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_src_addr,
    input  logic [ADDR_WIDTH-1:0] i_dst_addr,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_aborted,
    output logic                  o_rd_ready,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_wr_valid,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [DATA_WIDTH-1:0] o_wr_data,
    output logic [STRB_WIDTH-1:0] o_wr_strb,
    input  logic                  i_wr_ready
`ifdef DMA_XFER_PERF_EN
    ,
    output logic [31:0]           o_cycle_cnt
`endif
);

    // Address step per word; the adder wraps modulo 2^ADDR_WIDTH by construction.
    localparam logic [ADDR_WIDTH-1:0] ADDR_INC = ADDR_WIDTH'(STRB_WIDTH);

    dma_xfer_state_t       state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  abort_q, abort_d;
    logic                  aborted_q, aborted_d;
    logic                  abort_pend;

    // A same-cycle i_abort counts as pending so it takes effect at this word boundary.
    assign abort_pend = abort_q | i_abort;

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        rem_d     = rem_q;
        data_d    = data_q;
        abort_d   = abort_q;
        aborted_d = aborted_q;

        if (state_q != IDLE) begin
            abort_d = abort_pend;
        end

        unique case (state_q)
            IDLE: begin
                if (i_start) begin
                    src_d     = i_src_addr;
                    dst_d     = i_dst_addr;
                    rem_d     = i_len;
                    abort_d   = 1'b0;
                    aborted_d = 1'b0;
                    state_d   = (i_len == '0) ? DONE : RD;
                end
            end
            RD: begin
                if (i_rd_valid) begin
                    data_d  = i_rd_data;
                    src_d   = src_q + ADDR_INC;
                    // On abort the captured word is simply never written.
                    state_d = abort_pend ? DONE : WR;
                end
            end
            WR: begin
                if (i_wr_ready) begin
                    dst_d   = dst_q + ADDR_INC;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == LEN_WIDTH'(1) || abort_pend) ? DONE : RD;
                end
            end
            DONE: begin
                aborted_d = aborted_q | abort_q;
                abort_d   = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            rem_q     <= '0;
            data_q    <= '0;
            abort_q   <= 1'b0;
            aborted_q <= 1'b0;
        end else if (aenable) begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            rem_q     <= rem_d;
            data_q    <= data_d;
            abort_q   <= abort_d;
            aborted_q <= aborted_d;
        end
    end

    // Outputs are pure functions of registered state, so a frozen enable holds them.
    assign o_busy     = (state_q != IDLE);
    assign o_done     = (state_q == DONE);
    assign o_aborted  = aborted_q;
    assign o_rd_ready = (state_q == RD);
    assign o_rd_addr  = src_q;
    assign o_wr_valid = (state_q == WR);
    assign o_wr_addr  = dst_q;
    assign o_wr_data  = data_q;
    assign o_wr_strb  = '1;

`ifdef DMA_XFER_PERF_EN
    logic [31:0] cycle_cnt_q;

    always_ff @(posedge aclk) begin
        if (areset) begin
            cycle_cnt_q <= '0;
        end else if (aenable) begin
            if (state_q == IDLE && i_start) begin
                cycle_cnt_q <= '0;
            end else if (state_q != IDLE && cycle_cnt_q != 32'hFFFF_FFFF) begin
                cycle_cnt_q <= cycle_cnt_q + 32'd1;
            end
        end
    end

    assign o_cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_dma_xfer_ctrl.sv
// Directed self-checking bench for dma_xfer_ctrl: single word, four words with
// back-pressure, zero length, address wrap, abort, reset mid-transfer, enable freeze.
module tb_dma_xfer_ctrl;

    logic        aclk = 1'b0;
    logic        areset;
    logic        aenable;
    logic        i_start;
    logic [15:0] i_src_addr;
    logic [15:0] i_dst_addr;
    logic [15:0] i_len;
    logic        i_abort;
    logic        o_busy;
    logic        o_done;
    logic        o_aborted;
    logic        o_rd_ready;
    logic [15:0] o_rd_addr;
    logic        i_rd_valid;
    logic [63:0] i_rd_data;
    logic        o_wr_valid;
    logic [15:0] o_wr_addr;
    logic [63:0] o_wr_data;
    logic [7:0]  o_wr_strb;
    logic        i_wr_ready;
`ifdef DMA_XFER_PERF_EN
    logic [31:0] o_cycle_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int dly [8] = '{0, 0, 3, 1, 2, 0, 1, 3};
    int dly_idx = 0;

    always #5 aclk = ~aclk;

    dma_xfer_ctrl dut (
        .aclk       (aclk),
        .areset     (areset),
        .aenable    (aenable),
        .i_start    (i_start),
        .i_src_addr (i_src_addr),
        .i_dst_addr (i_dst_addr),
        .i_len      (i_len),
        .i_abort    (i_abort),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_aborted  (o_aborted),
        .o_rd_ready (o_rd_ready),
        .o_rd_addr  (o_rd_addr),
        .i_rd_valid (i_rd_valid),
        .i_rd_data  (i_rd_data),
        .o_wr_valid (o_wr_valid),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_wr_strb  (o_wr_strb),
        .i_wr_ready (i_wr_ready)
`ifdef DMA_XFER_PERF_EN
        ,
        .o_cycle_cnt(o_cycle_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        if (a == 16'h0100) return 64'hDEAD_BEEF_CAFE_F00D;
        return {a, ~a, a ^ 16'h1234, 16'hC0DE};
    endfunction

    task automatic check_reset_vals(input string name);
        check({name, ":busy"}, 64'(o_busy), 64'd0);
        check({name, ":done"}, 64'(o_done), 64'd0);
        check({name, ":aborted"}, 64'(o_aborted), 64'd0);
        check({name, ":rd_ready"}, 64'(o_rd_ready), 64'd0);
        check({name, ":wr_valid"}, 64'(o_wr_valid), 64'd0);
        check({name, ":rd_addr"}, 64'(o_rd_addr), 64'd0);
        check({name, ":wr_addr"}, 64'(o_wr_addr), 64'd0);
        check({name, ":wr_data"}, o_wr_data, 64'd0);
        check({name, ":wr_strb"}, 64'(o_wr_strb), 64'hFF);
    endtask

    // Drives one descriptor and acts as the read/write responder. abort_word,
    // freeze_word and reset_word select the word index at which that event is
    // injected (-1 for none).
    task automatic run_xfer(input string name, input logic [15:0] src, input logic [15:0] dst,
                            input int len, input int abort_word, input int freeze_word,
                            input int reset_word, input int exp_wr, input logic exp_aborted);
        logic [15:0] sa;
        logic [15:0] da;
        logic [63:0] held;
        int          nwr;
        int          t;
        int          d;
        sa  = src;
        da  = dst;
        nwr = 0;
        i_start    = 1'b1;
        i_src_addr = src;
        i_dst_addr = dst;
        i_len      = 16'(len);
        step();
        i_start = 1'b0;
        check({name, ":busy_at_start"}, 64'(o_busy), 64'd1);
        check({name, ":aborted_cleared"}, 64'(o_aborted), 64'd0);
        if (len == 0) begin
            check({name, ":done_at_start"}, 64'(o_done), 64'd1);
            check({name, ":no_rd_req"}, 64'(o_rd_ready), 64'd0);
            check({name, ":no_wr_req"}, 64'(o_wr_valid), 64'd0);
            step();
            check({name, ":done_end"}, 64'(o_done), 64'd0);
            check({name, ":busy_end"}, 64'(o_busy), 64'd0);
            return;
        end
        for (int w = 0; w < len; w++) begin
            t = 0;
            while (!o_rd_ready && t < 20) begin
                step();
                t++;
            end
            check({name, ":rd_req"}, 64'(o_rd_ready), 64'd1);
            check({name, ":rd_addr"}, 64'(o_rd_addr), 64'(sa));
            if (w == abort_word) begin
                i_abort = 1'b1;
                step();
                i_abort = 1'b0;
            end
            if (w == freeze_word) begin
                aenable    = 1'b0;
                i_rd_valid = 1'b1;
                i_rd_data  = '1;
                i_wr_ready = 1'b1;
                for (int f = 0; f < 5; f++) begin
                    step();
                    check({name, ":frz_rd_req"}, 64'(o_rd_ready), 64'd1);
                    check({name, ":frz_rd_addr"}, 64'(o_rd_addr), 64'(sa));
                    check({name, ":frz_wr_valid"}, 64'(o_wr_valid), 64'd0);
                end
                aenable    = 1'b1;
                i_rd_valid = 1'b0;
                i_wr_ready = 1'b0;
            end
            d = dly[dly_idx % 8];
            dly_idx++;
            repeat (d) begin
                step();
                check({name, ":rd_hold"}, {47'd0, o_rd_ready, o_rd_addr}, {47'd0, 1'b1, sa});
            end
            held       = mem_word(sa);
            i_rd_valid = 1'b1;
            i_rd_data  = held;
            step();
            i_rd_valid = 1'b0;
            sa = sa + 16'd8;
            if (w == abort_word) break;
            t = 0;
            while (!o_wr_valid && t < 20) begin
                step();
                t++;
            end
            check({name, ":wr_req"}, 64'(o_wr_valid), 64'd1);
            check({name, ":wr_addr"}, 64'(o_wr_addr), 64'(da));
            check({name, ":wr_data"}, o_wr_data, held);
            check({name, ":wr_strb"}, 64'(o_wr_strb), 64'hFF);
            if (w == reset_word) begin
                areset = 1'b1;
                step();
                areset = 1'b0;
                check_reset_vals({name, ":mid_reset"});
                return;
            end
            d = dly[dly_idx % 8];
            dly_idx++;
            repeat (d) begin
                step();
                check({name, ":wr_hold"}, {47'd0, o_wr_valid, o_wr_addr}, {47'd0, 1'b1, da});
            end
            i_wr_ready = 1'b1;
            step();
            i_wr_ready = 1'b0;
            nwr++;
            da = da + 16'd8;
        end
        check({name, ":done_pulse"}, 64'(o_done), 64'd1);
        check({name, ":writes"}, 64'(nwr), 64'(exp_wr));
        step();
        check({name, ":done_end"}, 64'(o_done), 64'd0);
        check({name, ":busy_end"}, 64'(o_busy), 64'd0);
        check({name, ":aborted"}, 64'(o_aborted), 64'(exp_aborted));
    endtask

    initial begin
        areset     = 1'b1;
        aenable    = 1'b1;
        i_start    = 1'b0;
        i_src_addr = '0;
        i_dst_addr = '0;
        i_len      = '0;
        i_abort    = 1'b0;
        i_rd_valid = 1'b0;
        i_rd_data  = '0;
        i_wr_ready = 1'b0;
        #1;
        repeat (3) step();
        areset = 1'b0;
        check_reset_vals("reset");

        // i_abort in IDLE must not leak into the next transfer.
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;

        run_xfer("single", 16'h0100, 16'h0200, 1, -1, -1, -1, 1, 1'b0);
        run_xfer("four",   16'h1000, 16'h2000, 4, -1, -1, -1, 4, 1'b0);
        run_xfer("zero",   16'h3000, 16'h4000, 0, -1, -1, -1, 0, 1'b0);
        run_xfer("wrap",   16'hFFF8, 16'h0000, 2, -1, -1, -1, 2, 1'b0);
        run_xfer("abort",  16'h5000, 16'h6000, 8,  2, -1, -1, 2, 1'b1);
        run_xfer("after",  16'h7000, 16'h7800, 1, -1, -1, -1, 1, 1'b0);
        run_xfer("rst",    16'h3000, 16'h4000, 4, -1, -1,  1, 0, 1'b0);
        run_xfer("freeze", 16'h8000, 16'h9000, 3, -1,  1, -1, 3, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
